busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
Instruction fetch stage of the single-cycle processor. It owns the PC register and fetches each instruction from instruction memory over a req/ack handshake. It presents the instruction to the decode and control logic, and holds it until the datapath signals retirement. It then computes the next PC from the branch/jump control signals and ALU results of the retiring instruction.

Parameters:
PC_INICIAL, 32'h0040_0000, PC value loaded on reset (start of .text)
LARG, 32, width of PC, addresses, instruction and immediate

Ports:
iCLK  in  1  system clock, rising edge
iRST_n  in  1  asynchronous active-low reset
iBranch  in  1  retiring instruction is a conditional branch (beq)
iJump  in  1  retiring instruction is jal or jalr
iJalr  in  1  retiring instruction is jalr (qualifies iJump)
iZero  in  1  ALU zero flag of the retiring instruction
iImm  in  LARG  sign-extended immediate of the retiring instruction
iALUResult  in  LARG  ALU result (rs1+imm for jalr)
iExecuta  in  1  retire strobe: the datapath has completed the instruction in oInstr
oMemReq  out  1  instruction memory read request
oMemAddr  out  LARG  read address (equals oPC)
iMemAck  in  1  memory has data on iMemData this cycle
iMemData  in  LARG  instruction word from memory
oPC  out  LARG  PC of the current instruction
oPC4  out  LARG  oPC+4 (link value for jal/jalr)
oInstr  out  LARG  current instruction; oInstr[6:0] drives the control decoder opcode
oValid  out  1  oInstr is valid and may be executed
oErro  out  1  misaligned next-PC trap, sticky until reset
oInstret  out  32  count of retired instructions

Behaviour:
- Reset (iRST_n=0, asynchronous): state=INICIO, PC=PC_INICIAL, oInstr=32'h0000_0013 (nop), oValid=0, oMemReq=0, oErro=0, oInstret=0. All outputs are registered except oPC4 and oMemAddr, which are combinational from PC.
- FSM states: INICIO, BUSCA, PRONTO, ERRO.
- INICIO: the first edge after reset release goes to BUSCA unconditionally. oMemReq is not asserted during or immediately at reset release.
- BUSCA: oMemReq=1, oMemAddr=PC, held stable until ack. On an edge with iMemAck=1: oInstr<=iMemData, oValid<=1, oMemReq<=0, go to PRONTO. Zero-wait memory is allowed: ack may arrive on the first BUSCA cycle. Minimum fetch latency is 1 cycle in BUSCA.
- PRONTO: oInstr and oPC are held stable, oValid=1. On an edge with iExecuta=1:
  - next PC is computed as:
    - iJump&iJalr -> iALUResult & ~1
    - iJump&!iJalr -> PC+iImm
    - iBranch&iZero -> PC+iImm
    - else PC+4
  - oValid<=0 and oInstret<=oInstret+1 (wraps modulo 2^32).
  - If next PC[1:0]!=0: PC is unchanged, oErro<=1, go to ERRO. Otherwise PC<=next PC, go to BUSCA.
- ERRO: oValid=0, oMemReq=0, oErro=1. Only reset exits this state.
- Ignored inputs: iMemAck outside BUSCA; iExecuta outside PRONTO; iBranch/iJump/iZero/iImm/iALUResult except on a PRONTO cycle with iExecuta=1.
- Simultaneous iBranch and iJump: jump has priority.
- All additions are modulo 2^LARG, so wrap-around at 32'hFFFF_FFFC+4 gives 0.
- Reset mid-fetch: the outstanding request is abandoned, and an ack arriving in INICIO is ignored.
- Steady-state throughput: one instruction per 2 cycles minimum (one BUSCA cycle plus one PRONTO cycle).

Decomposition:
- Shared package/Parametros.v: state enum (INICIO, BUSCA, PRONTO, ERRO), PC_INICIAL default, NOP constant 32'h0000_0013. Existing OPC_* constants remain there.
- Sub-module calc_prox_pc: combinational next-PC and misalignment check. Inputs PC, iImm, iALUResult, iBranch, iJump, iJalr, iZero. Outputs prox_pc, desalinhado.

Test Plan:
- Reset then zero-wait memory (iMemAck=1 whenever oMemReq), iExecuta=1 every PRONTO cycle, no branches -> oPC sequence 0x00400000, 0x00400004, 0x00400008; oValid high every 2nd cycle; oInstret=3 after third retire.
- Memory ack delayed 3 cycles -> oMemReq and oMemAddr held constant for 3 cycles; oInstr latched only on the ack edge; iMemAck pulse during PRONTO has no effect.
- PC=0x00400010, iBranch=1, iZero=1, iImm=-8 -> next oPC=0x00400008. Same with iZero=0 -> 0x00400014.
- jalr: iJump=1, iJalr=1, iALUResult=0x00400101 -> oPC=0x00400100. jal with iImm=0x20 at PC=0x00400000 -> oPC=0x00400020. iJump and iBranch both set -> jump target is taken.
- jal with iImm=0x6 -> oErro=1, oValid=0, oMemReq=0 indefinitely, PC unchanged; asserting iRST_n=0 then releasing -> oPC=0x00400000, oErro=0.
- Assert reset asynchronously mid-BUSCA, between clock edges -> outputs take reset values immediately. oInstret preloaded to 0xFFFFFFFF then one retire -> oInstret=0.

Source files
------------

// File: rtl/busca_instrucao_pkg.sv
// Shared definitions for the fetch stage: FSM states, reset PC, the canonical nop
// and the RV32I major opcodes used by the control decoder.
package busca_instrucao_pkg;

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    BUSCA  = 2'd1,
    PRONTO = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  localparam logic [31:0] PC_INICIAL_PADRAO = 32'h0040_0000;
  localparam logic [31:0] NOP               = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/busca_instrucao_calc_prox_pc.sv
// Combinational next-PC selection for the retiring instruction, plus the
// word-alignment check on the selected target.
module busca_instrucao_calc_prox_pc #(
  parameter int LARG = 32
) (
  input  logic [LARG-1:0] pc,
  input  logic [LARG-1:0] imm,
  input  logic [LARG-1:0] alu_result,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic            zero,
  output logic [LARG-1:0] prox_pc,
  output logic            desalinhado
);

  always_comb begin
    prox_pc = pc + LARG'(4);
    // Jumps win over a simultaneously flagged branch.
    if (jump && jalr) begin
      prox_pc = alu_result & ~LARG'(1);
    end else if (jump) begin
      prox_pc = pc + imm;
    end else if (branch && zero) begin
      prox_pc = pc + imm;
    end
    desalinhado = |prox_pc[1:0];
  end

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds
// the instruction until retirement, then steps to the next PC or traps.
module busca_instrucao
  import busca_instrucao_pkg::*;
#(
  parameter int              LARG       = 32,
  parameter logic [LARG-1:0] PC_INICIAL = PC_INICIAL_PADRAO
) (
  input  logic            iCLK,
  input  logic            iRST_n,
  input  logic            iBranch,
  input  logic            iJump,
  input  logic            iJalr,
  input  logic            iZero,
  input  logic [LARG-1:0] iImm,
  input  logic [LARG-1:0] iALUResult,
  input  logic            iExecuta,
  output logic            oMemReq,
  output logic [LARG-1:0] oMemAddr,
  input  logic            iMemAck,
  input  logic [LARG-1:0] iMemData,
  output logic [LARG-1:0] oPC,
  output logic [LARG-1:0] oPC4,
  output logic [LARG-1:0] oInstr,
  output logic            oValid,
  output logic            oErro,
  output logic [31:0]     oInstret
);

  estado_t         estado_reg;
  logic [LARG-1:0] prox_pc;
  logic            desalinhado;

  assign oMemAddr = oPC;
  assign oPC4     = oPC + LARG'(4);

  busca_instrucao_calc_prox_pc #(.LARG(LARG)) u_calc_prox_pc (
    .pc          (oPC),
    .imm         (iImm),
    .alu_result  (iALUResult),
    .branch      (iBranch),
    .jump        (iJump),
    .jalr        (iJalr),
    .zero        (iZero),
    .prox_pc     (prox_pc),
    .desalinhado (desalinhado)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      estado_reg <= INICIO;
      oPC        <= PC_INICIAL;
      oInstr     <= LARG'(NOP);
      oValid     <= 1'b0;
      oMemReq    <= 1'b0;
      oErro      <= 1'b0;
      oInstret   <= 32'd0;
    end else begin
      case (estado_reg)
        INICIO: begin
          // One idle edge after reset so a stale ack can never be taken.
          estado_reg <= BUSCA;
          oMemReq    <= 1'b1;
        end
        BUSCA: begin
          if (iMemAck) begin
            oInstr     <= iMemData;
            oValid     <= 1'b1;
            oMemReq    <= 1'b0;
            estado_reg <= PRONTO;
          end
        end
        PRONTO: begin
          if (iExecuta) begin
            oValid   <= 1'b0;
            oInstret <= oInstret + 32'd1;
            if (desalinhado) begin
              oErro      <= 1'b1;
              estado_reg <= ERRO;
            end else begin
              oPC        <= prox_pc;
              oMemReq    <= 1'b1;
              estado_reg <= BUSCA;
            end
          end
        end
        ERRO: begin
          oValid  <= 1'b0;
          oMemReq <= 1'b0;
          oErro   <= 1'b1;
        end
        default: estado_reg <= INICIO;
      endcase
    end
  end

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a transaction-level reference model is
// compared every cycle, plus literal checks on the documented scenarios.
module tb_busca_instrucao;

  logic        iCLK = 1'b0;
  logic        iRST_n = 1'b0;
  logic        iBranch = 1'b0, iJump = 1'b0, iJalr = 1'b0, iZero = 1'b0;
  logic [31:0] iImm = '0, iALUResult = '0;
  logic        iExecuta = 1'b0;
  logic        oMemReq;
  logic [31:0] oMemAddr;
  logic        iMemAck = 1'b0;
  logic [31:0] iMemData = '0;
  logic [31:0] oPC, oPC4, oInstr;
  logic        oValid, oErro;
  logic [31:0] oInstret;

  always #5 iCLK = ~iCLK;

  busca_instrucao dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iBranch(iBranch), .iJump(iJump), .iJalr(iJalr),
    .iZero(iZero), .iImm(iImm), .iALUResult(iALUResult), .iExecuta(iExecuta),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck), .iMemData(iMemData),
    .oPC(oPC), .oPC4(oPC4), .oInstr(oInstr), .oValid(oValid), .oErro(oErro),
    .oInstret(oInstret)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 4) ^ 32'h0000_A013;
  endfunction

  // Reference model: "started", "fetching", "holding", "trapped" as booleans.
  logic        m_started, m_fetch, m_ready, m_trap;
  logic [31:0] m_pc, m_instr, m_count;

  function automatic logic [31:0] target(input logic [31:0] pc);
    if (iJump) return iJalr ? (iALUResult - (iALUResult % 32'd2)) : (pc + iImm);
    if (iBranch && iZero) return pc + iImm;
    return pc + 32'd4;
  endfunction

  always @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      m_started <= 1'b0; m_fetch <= 1'b0; m_ready <= 1'b0; m_trap <= 1'b0;
      m_pc <= 32'h0040_0000; m_instr <= 32'h0000_0013; m_count <= 32'd0;
    end else if (!m_started) begin
      m_started <= 1'b1; m_fetch <= 1'b1;
    end else if (m_fetch && iMemAck) begin
      m_instr <= iMemData; m_fetch <= 1'b0; m_ready <= 1'b1;
    end else if (m_ready && iExecuta) begin
      m_count <= m_count + 32'd1;
      m_ready <= 1'b0;
      if (target(m_pc) % 32'd4 != 32'd0) m_trap <= 1'b1;
      else begin
        m_pc <= target(m_pc); m_fetch <= 1'b1;
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge iCLK) begin
    if (cmp_en) begin
      chk("cyc_pc", oPC, m_pc);
      chk("cyc_pc4", oPC4, m_pc + 32'd4);
      chk("cyc_memaddr", oMemAddr, m_pc);
      chk("cyc_memreq", 32'(oMemReq), 32'(m_fetch));
      chk("cyc_valid", 32'(oValid), 32'(m_ready));
      chk("cyc_erro", 32'(oErro), 32'(m_trap));
      chk("cyc_instr", oInstr, m_instr);
      chk("cyc_instret", oInstret, m_count);
    end
  end

  // Stimulus: memory responder with programmable latency plus retire strobe.
  int ack_delay = 0;
  int req_cnt   = 0;
  bit spur      = 1'b0;
  bit exec_en   = 1'b0;

  task automatic step();
    @(negedge iCLK);
    iMemAck  = spur || (oMemReq && req_cnt >= ack_delay);
    iMemData = spur ? 32'hDEAD_BEEF : mem_word(oMemAddr);
    req_cnt  = oMemReq ? req_cnt + 1 : 0;
    iExecuta = exec_en;
  endtask

  task automatic wait_valid();
    bit found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (oValid) found = 1'b1;
    end
    if (!found) begin
      n_checks++;
      $display("FAIL wait_valid: oValid stayed 0, required 1 within 20 cycles at %0t", $time);
    end
  endtask

  task automatic retire(input logic br, input logic jp, input logic jr, input logic zr,
                        input logic [31:0] imm, input logic [31:0] alu);
    wait_valid();
    iBranch = br; iJump = jp; iJalr = jr; iZero = zr; iImm = imm; iALUResult = alu;
    step();
    iBranch = 1'b0; iJump = 1'b0; iJalr = 1'b0; iZero = 1'b0; iImm = '0; iALUResult = '0;
  endtask

  initial begin
    repeat (2) @(negedge iCLK);
    chk("rst_pc", oPC, 32'h0040_0000);
    chk("rst_instr", oInstr, 32'h0000_0013);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_memreq", 32'(oMemReq), 32'd0);
    chk("rst_erro", 32'(oErro), 32'd0);
    chk("rst_instret", oInstret, 32'd0);
    cmp_en = 1'b1;

    iRST_n = 1'b1;
    #1 chk("release_memreq", 32'(oMemReq), 32'd0);
    step();
    chk("first_busca_memreq", 32'(oMemReq), 32'd1);

    // Zero-wait memory, retire every instruction, straight-line code.
    exec_en = 1'b1;
    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("seq_pc1", oPC, 32'h0040_0004);
    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("seq_pc2", oPC, 32'h0040_0008);
    ack_delay = 3;
    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("seq_pc3", oPC, 32'h0040_000C);
    chk("seq_instret3", oInstret, 32'd3);

    // Slow memory, then a stray ack while holding the instruction.
    exec_en = 1'b0;
    wait_valid();
    chk("slow_instr", oInstr, mem_word(32'h0040_000C));
    spur = 1'b1; step(); spur = 1'b0; step();
    chk("spur_instr", oInstr, mem_word(32'h0040_000C));
    chk("spur_valid", 32'(oValid), 32'd1);
    ack_delay = 0; exec_en = 1'b1;

    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("pc_10", oPC, 32'h0040_0010);
    retire(1, 0, 0, 1, 32'hFFFF_FFF8, 32'd0);
    chk("beq_taken", oPC, 32'h0040_0008);
    retire(0, 1, 0, 0, 32'd8, 32'd0);
    chk("jal_back", oPC, 32'h0040_0010);
    retire(1, 0, 0, 0, 32'hFFFF_FFF8, 32'd0);
    chk("beq_not_taken", oPC, 32'h0040_0014);
    retire(0, 1, 1, 0, 32'd0, 32'h0040_0101);
    chk("jalr_lsb", oPC, 32'h0040_0100);
    retire(1, 1, 1, 1, 32'h0000_0040, 32'h0040_0200);
    chk("jump_prio", oPC, 32'h0040_0200);
    retire(0, 1, 0, 0, 32'hFFBF_FDFC, 32'd0);
    chk("jal_top", oPC, 32'hFFFF_FFFC);
    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("pc_wrap", oPC, 32'h0000_0000);

    // Misaligned jal target traps and stays trapped.
    retire(0, 1, 0, 0, 32'd6, 32'd0);
    chk("trap_erro", 32'(oErro), 32'd1);
    chk("trap_valid", 32'(oValid), 32'd0);
    chk("trap_pc", oPC, 32'h0000_0000);
    repeat (5) step();
    chk("trap_memreq", 32'(oMemReq), 32'd0);
    chk("trap_erro_hold", 32'(oErro), 32'd1);
    chk("trap_instret", oInstret, 32'd12);

    // Reset exits the trap; an ack at release is ignored.
    iRST_n = 1'b0;
    step();
    chk("exit_pc", oPC, 32'h0040_0000);
    chk("exit_erro", 32'(oErro), 32'd0);
    iRST_n = 1'b1; iMemAck = 1'b1;
    step();
    chk("stale_ack_valid", 32'(oValid), 32'd0);
    chk("stale_ack_memreq", 32'(oMemReq), 32'd1);
    retire(0, 1, 0, 0, 32'h0000_0020, 32'd0);
    chk("jal_20", oPC, 32'h0040_0020);

    // Asynchronous reset in the middle of a slow fetch.
    ack_delay = 5;
    step();
    #2 iRST_n = 1'b0;
    #1;
    chk("async_memreq", 32'(oMemReq), 32'd0);
    chk("async_pc", oPC, 32'h0040_0000);
    chk("async_instret", oInstret, 32'd0);
    chk("async_instr", oInstr, 32'h0000_0013);
    step();
    iRST_n = 1'b1; ack_delay = 0;
    retire(0, 0, 0, 0, 32'd0, 32'd0);
    chk("after_async_pc", oPC, 32'h0040_0004);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
